// File: rtl/trig_pkg.sv
// trig_pkg: shared state encoding, default widths and clamp constant for the trigger pulse source.
package trig_pkg;
    localparam int CNT_W_DEF   = 24;
    localparam int BURST_W_DEF = 16;
    localparam int MIN_WIDTH   = 1;
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;
endpackage

// File: rtl/trig_sync.sv
// trig_sync: 2-flop synchroniser for an asynchronous level plus a registered rising-edge detect.
module trig_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);
    logic [2:0] sh_q;
    always_ff @(posedge clk_i) begin
        sh_q <= rst_i ? 3'b000 : {sh_q[1:0], async_i};
    end
    assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: programmable burst/continuous trigger pulse source with guaranteed low gap.
// Define TRIG_EXTSTART_EN to add the synchronised EXTTRIG start input.
module trig_pulse_gen
    import trig_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic [CNT_W-1:0]   PERIOD,
    input  logic [CNT_W-1:0]   WIDTH,
    input  logic [BURST_W-1:0] BURST,
`ifdef TRIG_EXTSTART_EN
    input  logic               EXTTRIG,
`endif
    output logic               TRIGOUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [BURST_W-1:0] PCOUNT
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, w_q, w_d, lw_q, lw_d;
    logic [BURST_W-1:0] n_q, n_d, pc_q, pc_d;
    logic               trig_q, trig_d, done_q, done_d, stop_q, stop_d;
    logic               start_req;
    logic [CNT_W-1:0]   w_clamp, lw_clamp;

`ifdef TRIG_EXTSTART_EN
    logic ext_rise;
    trig_sync u_sync (
        .clk_i  (CLK),
        .rst_i  (RST),
        .async_i(EXTTRIG),
        .rise_o (ext_rise)
    );
    assign start_req = START | ext_rise;
`else
    assign start_req = START;
`endif

    // Low phase length P-W, with P forced to at least W+1 so a low cycle always follows.
    assign w_clamp  = (WIDTH < CNT_W'(MIN_WIDTH)) ? CNT_W'(MIN_WIDTH) : WIDTH;
    assign lw_clamp = (PERIOD > w_clamp) ? PERIOD - w_clamp : CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        w_d     = w_q;
        lw_d    = lw_q;
        n_d     = n_q;
        pc_d    = pc_q;
        trig_d  = trig_q;
        done_d  = 1'b0;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_req && !STOP) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_W'(1);
                    w_d     = w_clamp;
                    lw_d    = lw_clamp;
                    n_d     = BURST;
                    pc_d    = BURST_W'(1);
                    trig_d  = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_HIGH: begin
                stop_d = stop_q | STOP;
                if (cnt_q == w_q) begin
                    state_d = (stop_q | STOP) ? S_IDLE : S_LOW;
                    cnt_d   = CNT_W'(1);
                    trig_d  = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            S_LOW: begin
                if (cnt_q == lw_q) begin
                    if (n_q == '0 || pc_q != n_q) begin
                        state_d = STOP ? S_IDLE : S_HIGH;
                        cnt_d   = CNT_W'(1);
                        trig_d  = !STOP;
                        pc_d    = STOP ? pc_q : pc_q + BURST_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (STOP) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            lw_q    <= '0;
            n_q     <= '0;
            pc_q    <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            lw_q    <= lw_d;
            n_q     <= n_d;
            pc_q    <= pc_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
        end
    end

    assign TRIGOUT = trig_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign PCOUNT  = pc_q;
endmodule

// File: tb/tb_trig_pulse_gen.sv
// tb_trig_pulse_gen: randomized self-checking bench against a per-cycle arithmetic model of the pulse train.
module tb_trig_pulse_gen;
    localparam int CW = 24;
    localparam int BW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1, START = 1'b0, STOP = 1'b0;
    logic [CW-1:0] PERIOD = '0, WIDTH = '0;
    logic [BW-1:0] BURST = '0;
    logic          TRIGOUT, BUSY, DONE;
    logic [BW-1:0] PCOUNT;
`ifdef TRIG_EXTSTART_EN
    logic          EXTTRIG = 1'b0;
`endif
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    trig_pulse_gen dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .STOP   (STOP),
        .PERIOD (PERIOD),
        .WIDTH  (WIDTH),
        .BURST  (BURST),
`ifdef TRIG_EXTSTART_EN
        .EXTTRIG(EXTTRIG),
`endif
        .TRIGOUT(TRIGOUT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .PCOUNT (PCOUNT)
    );

    function automatic int clamp_p(input int p, input int w);
        int wc;
        wc = (w < 1) ? 1 : w;
        return (p > wc) ? p : wc + 1;
    endfunction

    // Expected {TRIGOUT,BUSY,DONE,PCOUNT} in cycle t after a START accepted at edge 0.
    function automatic logic [BW+2:0] model(input int t, input int p, input int w, input int n);
        int wc, pc;
        logic trig, busy, done;
        wc = (w < 1) ? 1 : w;
        if (n == 0 || t < n * clamp_p(p, w)) begin
            trig = (t % clamp_p(p, w)) < wc;
            busy = 1'b1;
            done = 1'b0;
            pc   = t / clamp_p(p, w) + 1;
        end else begin
            trig = 1'b0;
            busy = 1'b0;
            done = (t == n * clamp_p(p, w));
            pc   = n;
        end
        return {trig, busy, done, BW'(pc)};
    endfunction

    // Called just after a negedge; START is accepted at the next posedge (edge 0).
    task automatic run(input int p, input int w, input int n, input int cycles, input bit noisy, input string name);
        logic [BW+2:0] exp;
        PERIOD = CW'(p);
        WIDTH  = CW'(w);
        BURST  = BW'(n);
        START  = 1'b1;
        STOP   = 1'b0;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge CLK);
            exp = model(t, p, w, n);
            checks++;
            if ({TRIGOUT, BUSY, DONE, PCOUNT} !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got trig/busy/done/pcount=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                         name, t, TRIGOUT, BUSY, DONE, PCOUNT, exp[BW+2], exp[BW+1], exp[BW], exp[BW-1:0]);
            end
            if (noisy && exp[BW+1]) begin
                START  = 1'($urandom_range(0, 1));
                PERIOD = CW'($urandom_range(0, 30));
                WIDTH  = CW'($urandom_range(0, 30));
                BURST  = BW'($urandom_range(0, 9));
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int pc, input bit check_pc);
        checks++;
        if (TRIGOUT !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || (check_pc && PCOUNT !== BW'(pc))) begin
            errors++;
            $display("FAIL %s: got trig/busy/done/pcount=%b/%b/%b/%0d expected 0/0/0/%0d",
                     name, TRIGOUT, BUSY, DONE, PCOUNT, pc);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        expect_idle("reset", 0, 1'b1);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_normal();
        run(10, 3, 4, 45, 1'b0, "normal");
    endtask

    task automatic test_clamp();
        run(0, 0, 2, 8, 1'b0, "clamp");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int p, w, n;
            p = $urandom_range(0, 12);
            w = $urandom_range(0, 6);
            n = $urandom_range(1, 4);
            run(p, w, n, n * clamp_p(p, w) + 3, 1'b1, "random");
        end
    endtask

    task automatic test_continuous_abort();
        run(4, 2, 0, 40, 1'b0, "continuous");
        @(negedge CLK);
        checks++;
        if ({TRIGOUT, BUSY, PCOUNT} !== {1'b1, 1'b1, BW'(11)}) begin
            errors++;
            $display("FAIL abort_c40: got trig/busy/pcount=%b/%b/%0d expected 1/1/11", TRIGOUT, BUSY, PCOUNT);
        end
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        checks++;
        if ({TRIGOUT, BUSY, DONE, PCOUNT} !== {1'b1, 1'b1, 1'b0, BW'(11)}) begin
            errors++;
            $display("FAIL abort_c41: got trig/busy/done/pcount=%b/%b/%b/%0d expected 1/1/0/11", TRIGOUT, BUSY, DONE, PCOUNT);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge CLK);
            expect_idle("abort_tail", 11, 1'b1);
        end
    endtask

    task automatic test_start_stop();
        START = 1'b1;
        STOP  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge CLK);
            expect_idle("start_stop", 0, 1'b0);
        end
        START = 1'b0;
        STOP  = 1'b0;
    endtask

    task automatic test_back_to_back();
        run(10, 3, 2, 25, 1'b1, "midburst_start");
        run(3, 1, 3, 12, 1'b0, "back_to_back");
    endtask

    task automatic test_reset_mid();
        run(20, 8, 1, 5, 1'b0, "rstmid_pre");
        RST = 1'b1;
        @(negedge CLK);
        expect_idle("rstmid", 0, 1'b1);
        RST = 1'b0;
        @(negedge CLK);
        run(20, 8, 1, 23, 1'b0, "rstmid_restart");
    endtask

`ifdef TRIG_EXTSTART_EN
    task automatic test_ext();
        logic [BW+2:0] exp;
        RST = 1'b1;
        @(negedge CLK);
        RST     = 1'b0;
        PERIOD  = CW'(4);
        WIDTH   = CW'(1);
        BURST   = BW'(1);
        EXTTRIG = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge CLK);
            exp = (t < 2) ? '0 : model(t - 2, 4, 1, 1);
            checks++;
            if ({TRIGOUT, BUSY, DONE, PCOUNT} !== exp) begin
                errors++;
                $display("FAIL ext cycle %0d: got trig/busy/done/pcount=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                         t, TRIGOUT, BUSY, DONE, PCOUNT, exp[BW+2], exp[BW+1], exp[BW], exp[BW-1:0]);
            end
        end
        EXTTRIG = 1'b0;
        @(negedge CLK);
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_clamp();
        test_random();
        test_continuous_abort();
        test_start_stop();
        test_back_to_back();
        test_reset_mid();
`ifdef TRIG_EXTSTART_EN
        test_ext();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
